// File: rtl/ps2_pkg.sv
// Scan-code constants, entry FSM state type and hex-key decoder shared by the PS/2 entry path.
// Pure definitions; no logic or state.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BRK,
        S_EXT,
        S_EXT_BRK
    } ps2_state_t;

    // Returns {valid, nibble}; valid is 0 for any non-hex key.
    function automatic logic [4:0] hex_of(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h45:   r = 5'h10;
            8'h16:   r = 5'h11;
            8'h1E:   r = 5'h12;
            8'h26:   r = 5'h13;
            8'h25:   r = 5'h14;
            8'h2E:   r = 5'h15;
            8'h36:   r = 5'h16;
            8'h3D:   r = 5'h17;
            8'h3E:   r = 5'h18;
            8'h46:   r = 5'h19;
            8'h1C:   r = 5'h1A;
            8'h32:   r = 5'h1B;
            8'h21:   r = 5'h1C;
            8'h23:   r = 5'h1D;
            8'h24:   r = 5'h1E;
            8'h2B:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Counts idle cycles while a scan-code prefix is pending; o_expire strobes on the
// TIMEOUT_CYCLES-th idle cycle. A clear in the same cycle suppresses the strobe.
module ps2_prefix_timer
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_run && !i_clear && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || i_clear || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ps2_entry_controller.sv
// Decodes PS/2 make/break/extended bytes into hex-digit edits and commits the buffer on Enter.
// All outputs registered; they update on the edge that samples scan_valid.
module ps2_entry_controller
    import ps2_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit REPEAT_EN      = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            scan_code,
    input  logic                  scan_valid,
    output logic [4*DIGITS-1:0]   edit_numb,
    output logic [DIGITS-1:0]     edit_mask,
    output logic [4*DIGITS-1:0]   NUMB,
    output logic [DIGITS-1:0]     MASK,
    output logic                  commit,
    output logic                  full,
    output logic                  err
);

    ps2_state_t            r_state, w_state_nxt;
    logic [4*DIGITS-1:0]   r_numb, w_numb_nxt, r_cnumb, w_cnumb_nxt;
    logic [DIGITS-1:0]     r_mask, w_mask_nxt, r_cmask, w_cmask_nxt;
    logic [7:0]            r_held, w_held_nxt;
    logic                  r_commit, w_commit_nxt, r_err, w_err_nxt;
    logic                  w_expire, w_full, w_repeat;
    logic [4:0]            w_hex;

    ps2_prefix_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_run    (r_state != S_IDLE),
        .i_clear  (scan_valid),
        .o_expire (w_expire)
    );

    assign w_hex    = hex_of(scan_code);
    assign w_full   = &r_mask;
    assign w_repeat = !REPEAT_EN && (r_held != 8'h00) && (scan_code == r_held);

    always_comb begin
        w_state_nxt  = r_state;
        w_numb_nxt   = r_numb;
        w_mask_nxt   = r_mask;
        w_cnumb_nxt  = r_cnumb;
        w_cmask_nxt  = r_cmask;
        w_held_nxt   = r_held;
        w_commit_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (scan_valid) begin
                    if (scan_code == SC_BREAK) begin
                        w_state_nxt = S_BRK;
                    end else if (scan_code == SC_EXT) begin
                        w_state_nxt = S_EXT;
                    end else begin
                        w_held_nxt = scan_code;
                        if (!w_repeat) begin
                            if (w_hex[4]) begin
                                if (w_full) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_numb_nxt = {r_numb[4*DIGITS-5:0], w_hex[3:0]};
                                    w_mask_nxt = {r_mask[DIGITS-2:0], 1'b1};
                                end
                            end else if (scan_code == SC_BKSP) begin
                                w_numb_nxt = {4'h0, r_numb[4*DIGITS-1:4]};
                                w_mask_nxt = {1'b0, r_mask[DIGITS-1:1]};
                            end else if (scan_code == SC_ESC) begin
                                w_numb_nxt = '0;
                                w_mask_nxt = '0;
                            end else if (scan_code == SC_ENTER) begin
                                w_cnumb_nxt  = r_numb;
                                w_cmask_nxt  = r_mask;
                                w_commit_nxt = 1'b1;
                                w_numb_nxt   = '0;
                                w_mask_nxt   = '0;
                            end
                        end
                    end
                end
            end
            S_EXT: begin
                if (scan_valid) begin
                    w_state_nxt = (scan_code == SC_BREAK) ? S_EXT_BRK : S_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            S_BRK: begin
                if (scan_valid) begin
                    if (scan_code == r_held) begin
                        w_held_nxt = 8'h00;
                    end
                    w_state_nxt = S_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                if (scan_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_numb   <= '0;
            r_mask   <= '0;
            r_cnumb  <= '0;
            r_cmask  <= '0;
            r_held   <= 8'h00;
            r_commit <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_numb   <= w_numb_nxt;
            r_mask   <= w_mask_nxt;
            r_cnumb  <= w_cnumb_nxt;
            r_cmask  <= w_cmask_nxt;
            r_held   <= w_held_nxt;
            r_commit <= w_commit_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign edit_numb = r_numb;
    assign edit_mask = r_mask;
    assign NUMB      = r_cnumb;
    assign MASK      = r_cmask;
    assign commit    = r_commit;
    assign err       = r_err;
    assign full      = w_full;

endmodule

// File: tb/tb_ps2_entry_controller.sv
// Directed-vector bench for ps2_entry_controller with a shortened prefix timeout.
module tb_ps2_entry_controller;
    import ps2_pkg::*;

    localparam int DIGITS = 8;
    localparam int TMO    = 40;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [7:0]          scan_code;
    logic                scan_valid;
    logic [4*DIGITS-1:0] edit_numb, NUMB;
    logic [DIGITS-1:0]   edit_mask, MASK;
    logic                commit, full, err;

    int vectors     = 0;
    int miscompares = 0;

    ps2_entry_controller #(
        .DIGITS         (DIGITS),
        .TIMEOUT_CYCLES (TMO),
        .REPEAT_EN      (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .edit_numb  (edit_numb),
        .edit_mask  (edit_mask),
        .NUMB       (NUMB),
        .MASK       (MASK),
        .commit     (commit),
        .full       (full),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Byte is sampled on the posedge between the two negedges; outputs read afterwards.
    task automatic send(input logic [7:0] code);
        @(negedge clk);
        scan_code  = code;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic press(input logic [7:0] code, output logic c, output logic e);
        send(code);
        c = commit;
        e = err;
        send(SC_BREAK);
        send(code);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({edit_numb, edit_mask, NUMB, MASK, commit, full, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got numb=%h mask=%h NUMB=%h MASK=%h c=%b f=%b e=%b want all 0",
                     edit_numb, edit_mask, NUMB, MASK, commit, full, err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_commit();
        logic [7:0] seq [9];
        int ncommit;
        seq = '{8'h16, 8'hF0, 8'h16, 8'h1E, 8'hF0, 8'h1E, 8'h5A, 8'hF0, 8'h5A};
        ncommit = 0;
        for (int i = 0; i < 9; i++) begin
            send(seq[i]);
            if (commit === 1'b1) ncommit++;
        end
        vectors++;
        if (ncommit != 1) begin
            miscompares++;
            $display("FAIL commit_count got %0d want 1", ncommit);
        end
        vectors++;
        if (NUMB !== 32'h0000_0012 || MASK !== 8'h03) begin
            miscompares++;
            $display("FAIL commit_value got NUMB=%h MASK=%h want 00000012/03", NUMB, MASK);
        end
        vectors++;
        if (edit_mask !== 8'h00 || edit_numb !== 32'h0) begin
            miscompares++;
            $display("FAIL commit_clears_live got numb=%h mask=%h want 0/0", edit_numb, edit_mask);
        end
    endtask

    task automatic test_full();
        logic [7:0] keys [9];
        logic c, e;
        int nerr;
        keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        nerr = 0;
        for (int i = 0; i < 9; i++) begin
            press(keys[i], c, e);
            if (i < 8 && e === 1'b1) nerr++;
            if (i == 6) begin
                vectors++;
                if (full !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_at_7 got %b want 0", full);
                end
            end
            if (i == 7) begin
                vectors++;
                if (full !== 1'b1 || edit_numb !== 32'h1234_5678) begin
                    miscompares++;
                    $display("FAIL full_at_8 got full=%b numb=%h want 1/12345678", full, edit_numb);
                end
            end
            if (i == 8) begin
                vectors++;
                if (e !== 1'b1) begin
                    miscompares++;
                    $display("FAIL full_reject_err got %b want 1", e);
                end
                vectors++;
                if (edit_numb !== 32'h1234_5678 || edit_mask !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL full_reject_buf got numb=%h mask=%h want 12345678/FF", edit_numb, edit_mask);
                end
            end
        end
        vectors++;
        if (nerr != 0) begin
            miscompares++;
            $display("FAIL full_spurious_err got %0d want 0", nerr);
        end
        press(SC_ESC, c, e);
    endtask

    task automatic test_edit();
        logic c, e;
        press(8'h1C, c, e);
        press(8'h32, c, e);
        press(8'h21, c, e);
        vectors++;
        if (edit_numb !== 32'h0000_0ABC || edit_mask !== 8'h07) begin
            miscompares++;
            $display("FAIL edit_abc got numb=%h mask=%h want 00000ABC/07", edit_numb, edit_mask);
        end
        press(SC_BKSP, c, e);
        press(SC_BKSP, c, e);
        vectors++;
        if (edit_numb !== 32'h0000_000A || edit_mask !== 8'h01) begin
            miscompares++;
            $display("FAIL edit_bksp got numb=%h mask=%h want 0000000A/01", edit_numb, edit_mask);
        end
        press(SC_ESC, c, e);
        vectors++;
        if (edit_numb !== 32'h0 || edit_mask !== 8'h00) begin
            miscompares++;
            $display("FAIL edit_esc got numb=%h mask=%h want 0/0", edit_numb, edit_mask);
        end
        press(SC_BKSP, c, e);
        vectors++;
        if (edit_numb !== 32'h0 || edit_mask !== 8'h00 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL edit_bksp_empty got numb=%h mask=%h err=%b want 0/0/0", edit_numb, edit_mask, e);
        end
        press(SC_ENTER, c, e);
        vectors++;
        if (c !== 1'b1 || NUMB !== 32'h0 || MASK !== 8'h00) begin
            miscompares++;
            $display("FAIL edit_empty_enter got c=%b NUMB=%h MASK=%h want 1/0/0", c, NUMB, MASK);
        end
    endtask

    task automatic test_repeat();
        logic [7:0] seq [6];
        seq = '{8'h16, 8'h16, 8'h16, 8'hF0, 8'h16, 8'h16};
        for (int i = 0; i < 6; i++) send(seq[i]);
        vectors++;
        if (edit_numb !== 32'h0000_0011 || edit_mask !== 8'h03) begin
            miscompares++;
            $display("FAIL repeat_suppress got numb=%h mask=%h want 00000011/03", edit_numb, edit_mask);
        end
        send(SC_ENTER);
        vectors++;
        if (commit !== 1'b1 || NUMB !== 32'h0000_0011 || MASK !== 8'h03) begin
            miscompares++;
            $display("FAIL repeat_commit got c=%b NUMB=%h MASK=%h want 1/00000011/03", commit, NUMB, MASK);
        end
        send(SC_BREAK);
        send(SC_ENTER);
    endtask

    task automatic test_timeout();
        int n;
        send(SC_BREAK);
        n = 0;
        while (err !== 1'b1 && n < TMO + 10) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != TMO) begin
            miscompares++;
            $display("FAIL timeout_cycles got %0d want %0d", n, TMO);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse_width got err=%b want 0", err);
        end
        send(8'h16);
        vectors++;
        if (edit_numb !== 32'h0000_0001 || edit_mask !== 8'h01) begin
            miscompares++;
            $display("FAIL timeout_then_make got numb=%h mask=%h want 00000001/01", edit_numb, edit_mask);
        end
        send(SC_BREAK);
        send(8'h16);
    endtask

    task automatic test_mid_reset();
        logic c, e;
        press(8'h1E, c, e);
        send(SC_EXT);
        send(SC_ENTER);
        vectors++;
        if (commit !== 1'b0 || edit_numb !== 32'h0000_0012 || NUMB !== 32'h0000_0011) begin
            miscompares++;
            $display("FAIL ext_enter got c=%b numb=%h NUMB=%h want 0/00000012/00000011", commit, edit_numb, NUMB);
        end
        send(SC_BREAK);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({edit_numb, edit_mask, NUMB, MASK, commit, full, err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got numb=%h mask=%h NUMB=%h MASK=%h want all 0",
                     edit_numb, edit_mask, NUMB, MASK);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h16);
        vectors++;
        if (edit_numb !== 32'h0000_0001 || edit_mask !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_then_make got numb=%h mask=%h want 00000001/01", edit_numb, edit_mask);
        end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_full();
        test_edit();
        test_repeat();
        test_timeout();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
